alu_sched: RTL

Sequencer and two-port arbiter for the shared 16-bit combinational ALU. Two requesters (port 0: instruction datapath; port 1: stack unit) issue operations through valid/ready handshakes. The block grants one requester at a time, registers its operands into the ALU, captures the result and NZP flags, and returns them on the granted port's response channel. It also owns the architectural NZP flag register, so flag-update and flag-hold rules are enforced in one place.

---
 rtl/alu_sched.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_sched.sv
// alu_sched: sequencer and two-port arbiter for the shared combinational ALU.
// Grants one requester per IDLE visit, registers its operands into the ALU,
// captures result/flags by opcode class, and returns them on the granted
// port's response channel. Owns the architectural NZP flag register.
// Optional feature macro: ALU_SCHED_RR_EN (round-robin arbitration);
// when undefined, port 0 has fixed priority and no pointer register exists.
module alu_sched #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_res,
  output logic [2:0]       rsp0_nzp,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_res,
  output logic [2:0]       rsp1_nzp,
  input  logic             rsp1_ready,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_p,
  output logic [2:0]       nzp_q,
  output logic             busy
);

  localparam logic [OPW-1:0] OpLastAlu = OPW'(8);
  localparam logic [OPW-1:0] OpFetchA  = OPW'(11);
  localparam logic [OPW-1:0] OpFetchB  = OPW'(12);
  localparam logic [OPW-1:0] OpHold    = {OPW{1'b1}};

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           r_state, w_state_d;
  logic             r_gnt;   // port that owns the current operation
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic [2:0]       r_nzp;

  logic w_any_req;
  logic w_sel;      // port chosen in this IDLE cycle (0 or 1)
  logic w_accept;
  logic w_rsp_done;

  assign w_any_req = req0_valid | req1_valid;
  // rst gating keeps ready low while reset is held
  assign w_accept  = (r_state == StIdle) && w_any_req && !rst;

`ifdef ALU_SCHED_RR_EN
  logic r_rr;  // preferred port on contention: the one not granted last

  // Pick the preferred port on contention, otherwise whichever is valid
  always_comb begin
    w_sel = !req0_valid;
    if (req0_valid && req1_valid) w_sel = r_rr;
  end

  // Round-robin pointer flips away from every granted port
  always_ff @(posedge clk) begin
    if (rst)           r_rr <= 1'b0;
    else if (w_accept) r_rr <= ~w_sel;
  end
`else
  // Fixed priority: port 1 only when port 0 is idle
  always_comb begin
    w_sel = !req0_valid;
  end
`endif

  assign req0_ready = w_accept && !w_sel;
  assign req1_ready = w_accept && w_sel;
  assign w_rsp_done = (r_state == StResp) && (r_gnt ? rsp1_ready : rsp0_ready);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_d = StExec;
      StExec:  w_state_d = StResp;
      StResp:  if (w_rsp_done) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Latch the granted request's operands at acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt <= 1'b0;
      r_op  <= OpHold;
      r_a   <= '0;
      r_b   <= '0;
    end else if (w_accept) begin
      r_gnt <= w_sel;
      r_op  <= w_sel ? req1_op : req0_op;
      r_a   <= w_sel ? req1_a  : req0_a;
      r_b   <= w_sel ? req1_b  : req0_b;
    end
  end

  // Capture result and flags in EXEC according to opcode class
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res <= '0;
      r_nzp <= 3'b010;
    end else if (r_state == StExec) begin
      if (r_op <= OpLastAlu) begin
        r_res <= alu_res;
        r_nzp <= {alu_n, alu_z, alu_p};
      end else if (r_op == OpFetchA || r_op == OpFetchB) begin
        r_res <= r_a;
      end else if (r_op == OpHold) begin
        r_res <= r_res;
      end else begin
        r_res <= '0;
      end
    end
  end

  // ALU drive and response outputs; responses are zeroed when not valid
  always_comb begin
    alu_op     = OpHold;
    alu_a      = '0;
    alu_b      = '0;
    if (r_state == StExec) begin
      alu_op = r_op;
      alu_a  = r_a;
      alu_b  = r_b;
    end
    rsp0_valid = (r_state == StResp) && !r_gnt;
    rsp1_valid = (r_state == StResp) && r_gnt;
    rsp0_res   = rsp0_valid ? r_res : '0;
    rsp0_nzp   = rsp0_valid ? r_nzp : 3'b000;
    rsp1_res   = rsp1_valid ? r_res : '0;
    rsp1_nzp   = rsp1_valid ? r_nzp : 3'b000;
    nzp_q      = r_nzp;
    busy       = (r_state != StIdle);
  end

endmodule
